// File: rtl/serial_word_rx_if.sv
// Signal bundle for the display serial receive link: raw serial pins in, word handshake and
// status out.
interface serial_word_rx_if #(
    parameter int WIDTH = 28
);
    logic             sck;
    logic             cs_n;
    logic             sdi;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    // master: the receiver; slave: the pin driver plus word consumer
    modport master (
        input  sck, cs_n, sdi, ready,
        output data, valid, busy, frame_err, overrun
    );

    modport slave (
        output sck, cs_n, sdi, ready,
        input  data, valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_word_rx.sv
// Oversampling receiver for the chip-select framed, MSB-first display serial link.
// Rebuilds WIDTH-bit words in the clk domain and hands them out on a valid/ready port.
module serial_word_rx #(
    parameter int WIDTH = 28
) (
    input logic             clk,
    input logic             reset,
    serial_word_rx_if.master bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic             sck_s1, sck_s2, sck_s3;
    logic             cs_s1, cs_s2, cs_s3;
    logic             sdi_s1, sdi_s2;
    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] shift;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             frame_err;
    logic             overrun;
    logic [1:0]       warm;
    logic             armed;

    logic             sck_rise, cs_fall, cs_rise;
    logic             word_done;
    logic [WIDTH-1:0] next_word;
    logic [CW-1:0]    cnt_next;

    assign sck_rise  = sck_s2 & ~sck_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;
    assign next_word = {shift, sdi_s2};

    always_comb begin
        word_done = 1'b0;
        cnt_next  = cnt;
        if (state == RECV && sck_rise) begin
            if (cnt == CW'(WIDTH - 1)) begin
                word_done = 1'b1;
                cnt_next  = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_s3    <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_s3     <= 1'b1;
            sdi_s1    <= 1'b0;
            sdi_s2    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            warm      <= '0;
            armed     <= 1'b0;
        end else begin
            sck_s1    <= bus.sck;
            sck_s2    <= sck_s1;
            sck_s3    <= sck_s2;
            cs_s1     <= bus.cs_n;
            cs_s2     <= cs_s1;
            cs_s3     <= cs_s2;
            sdi_s1    <= bus.sdi;
            sdi_s2    <= sdi_s1;
            frame_err <= 1'b0;

            // The cs_n chain restarts from its reset value; only trust a falling edge once the
            // pipe is full of real pin samples and the pin has been seen high.
            if (warm != 2'd3) warm <= warm + 2'd1;
            if (warm == 2'd3 && cs_s3) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state <= RECV;
                        cnt   <= '0;
                        shift <= '0;
                    end
                end
                RECV: begin
                    if (sck_rise) begin
                        shift <= next_word[WIDTH-2:0];
                        cnt   <= cnt_next;
                    end
                    // A bit arriving with the closing edge is counted before the close.
                    if (cs_rise) begin
                        state <= IDLE;
                        cnt   <= '0;
                        shift <= '0;
                        if (cnt_next != '0) frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (word_done) begin
                if (!valid || bus.ready) begin
                    data  <= next_word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && bus.ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.data      = data;
    assign bus.valid     = valid;
    assign bus.busy      = (state == RECV);
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_serial_word_rx.sv
// Randomised and directed bench for serial_word_rx against a bit-list model of the link.
module tb_serial_word_rx;
    localparam int WIDTH = 28;

    logic clk = 1'b0;
    logic reset;

    serial_word_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_word_rx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic bits[$];
    int fe_seen = 0;
    int fe_exp = 0;
    int vcycles = 0;
    int delivered = 0;
    logic [WIDTH-1:0] last_data = '0;
    logic rand_ready = 1'b0;
    logic exp_overrun = 1'b0;
    logic fe_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Per-cycle monitor: every accepted word must be the next one the model predicts.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            fe_prev = 1'b0;
        end else begin
            if (bus.frame_err) begin
                fe_seen++;
                if (fe_prev) begin
                    total++;
                    bad++;
                    $display("FAIL frame_err_width: got 2+ cycles want 1");
                end
            end
            fe_prev = bus.frame_err;
            if (bus.valid) vcycles++;
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", bus.data);
                end else begin
                    check("word", bus.data, exp_q.pop_front());
                end
                delivered++;
                last_data = bus.data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_ready) bus.ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic add_word(input logic [WIDTH-1:0] w, input int n);
        for (int i = WIDTH - 1; i >= WIDTH - n; i--) bits.push_back(w[i]);
    endtask

    // Model: every full WIDTH bits of the frame is a word; leftover bits mean a frame error.
    task automatic model_frame(input bit deliver);
        int n;
        logic [WIDTH-1:0] w;
        n = bits.size();
        for (int k = 0; k < n / WIDTH; k++) begin
            w = '0;
            for (int j = 0; j < WIDTH; j++) w = (w << 1) | WIDTH'(bits[k * WIDTH + j]);
            if (deliver) exp_q.push_back(w);
        end
        if (n % WIDTH != 0) fe_exp++;
    endtask

    task automatic send_bit(input logic b, input bit close_with_it);
        bus.sdi = b;
        repeat (4) tick();
        bus.sck = 1'b1;
        if (close_with_it) bus.cs_n = 1'b1;
        repeat (4) tick();
        bus.sck = 1'b0;
    endtask

    task automatic send_frame(input bit coincident);
        int n;
        n = bits.size();
        bus.cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) send_bit(bits[i], coincident && (i == n - 1));
        if (!coincident) begin
            check("busy_in_frame", bus.busy, 1);
            repeat (2) tick();
            bus.cs_n = 1'b1;
        end
        repeat (10) tick();
        check("busy_after_frame", bus.busy, 0);
        check("frame_err_count", fe_seen, fe_exp);
        check("overrun", bus.overrun, exp_overrun);
        bits.delete();
    endtask

    initial begin
        int d0;
        int nw;
        int part;
        reset = 1'b1;
        bus.sck = 1'b0;
        bus.cs_n = 1'b1;
        bus.sdi = 1'b0;
        bus.ready = 1'b1;
        repeat (3) tick();
        check("rst_data", bus.data, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1'b0;
        repeat (6) tick();

        // Single word, consumer always ready
        add_word(28'hABCDEF1, WIDTH);
        model_frame(1);
        check("model_pin_abcdef1", exp_q[0], 28'hABCDEF1);
        vcycles = 0;
        send_frame(0);
        check("data_abcdef1", last_data, 28'hABCDEF1);
        check("valid_pulse_cycles", vcycles, 1);

        // Two words back to back in one frame
        add_word(28'h0000001, WIDTH);
        add_word(28'hFFFFFFF, WIDTH);
        model_frame(1);
        d0 = delivered;
        send_frame(0);
        check("two_words_count", delivered - d0, 2);
        check("data_fffffff", last_data, 28'hFFFFFFF);

        // Partial frame: 10 bits only
        add_word(28'h5555555, 10);
        model_frame(1);
        check("model_pin_partial_err", fe_exp, 1);
        d0 = delivered;
        vcycles = 0;
        send_frame(0);
        check("partial_no_word", delivered - d0, 0);
        check("partial_no_valid", vcycles, 0);
        check("partial_data_kept", bus.data, 28'hFFFFFFF);

        // Consumer stalled across two words: the second one is dropped
        bus.ready = 1'b0;
        add_word(28'h1234567, WIDTH);
        add_word(28'h7654321, WIDTH);
        model_frame(0);
        exp_q.push_back(28'h1234567);
        exp_overrun = 1'b1;
        send_frame(0);
        check("stall_data", bus.data, 28'h1234567);
        check("stall_valid", bus.valid, 1);
        bus.ready = 1'b1;
        repeat (3) tick();
        check("stall_valid_cleared", bus.valid, 0);
        check("stall_data_kept", bus.data, 28'h1234567);
        check("stall_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a frame
        bus.cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 14; i++) send_bit(1'($urandom_range(0, 1)), 0);
        reset = 1'b1;
        repeat (2) tick();
        check("midrst_data", bus.data, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_overrun", bus.overrun, 0);
        reset = 1'b0;
        exp_overrun = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        check("stale_frame_ignored", bus.busy, 0);
        bus.cs_n = 1'b1;
        repeat (8) tick();
        add_word(28'h0F0F0F0, WIDTH);
        model_frame(1);
        send_frame(0);
        check("after_rst_data", last_data, 28'h0F0F0F0);

        // Last bit lands with the closing chip-select edge
        add_word(28'h8000001, WIDTH);
        model_frame(1);
        send_frame(1);
        check("coincident_data", last_data, 28'h8000001);

        // Random frames with a jittery but timely consumer
        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            nw = $urandom_range(0, 2);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH - 1) : 0;
            if (nw == 0 && part == 0) nw = 1;
            for (int k = 0; k < nw; k++) add_word(WIDTH'($urandom), WIDTH);
            if (part != 0) add_word(WIDTH'($urandom), part);
            model_frame(1);
            send_frame($urandom_range(0, 3) == 0);
        end
        rand_ready = 1'b0;
        bus.ready = 1'b1;
        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
